cam_capture_rgb444: RTL
=======================

Name: cam_capture_rgb444

Overview:
- Camera-side capture stage between the OV7670-style parallel interface and the dual-port frame buffer. The VGA path reads that buffer.
- Assembles two-byte RGB444 pixels (byte1 = xxxxRRRR, byte2 = GGGGBBBB) into 12-bit words.
- Writes them row-aligned into a 160x120 buffer. Reports frame completion and framing errors.
- Runs entirely on the camera pixel clock. At top level, clk is driven by CAM_pclk. Camera data is launched on negedge and sampled here on posedge.

Parameters:
- H_PIXELS, 160, pixels per line (2*H_PIXELS bytes per href).
- V_PIXELS, 120, lines per frame.
- AW, 15, buffer address width (must satisfy 2^AW >= H_PIXELS*V_PIXELS).
- DW, 12, pixel width (RGB444).

Ports:
- clk  in  1  capture clock (CAM_pclk domain).
- rst  in  1  asynchronous, active-low reset.
- CAM_vsync  in  1  frame sync; high = vertical blanking.
- CAM_href  in  1  line valid; high while line bytes present.
- CAM_px_data  in  8  camera byte.
- DP_RAM_addr_in  out  AW  buffer write address.
- DP_RAM_data_in  out  DW  pixel {R,G,B}.
- DP_RAM_regW  out  1  write strobe, one cycle per pixel.
- frame_done  out  1  one-cycle pulse at end of each captured frame.
- err_half_px  out  1  sticky: href fell between byte1 and byte2.
- err_overrun  out  1  sticky: pixel dropped (line > H_PIXELS or row >= V_PIXELS).

Behaviour:
Clocking and reset:
- One clock, asynchronous active-low reset.
- All outputs are registered. On rst=0, every output is 0, state=IDLE, and the column, row and address registers are 0.
- Reset mid-frame abandons the frame. No write occurs until a full vsync high→low sequence is seen after release.

States:
- IDLE: wait for CAM_vsync=1, then go to VBLANK. A frame already in progress at reset release is never partially captured.
- VBLANK: while vsync=1, hold. On a sampled vsync=0, clear row=0, col=0, base=0, then go to BYTE1.
- BYTE1:
  - href=1: latch CAM_px_data[3:0] as R, go to BYTE2.
  - href=0 with a falling edge of href relative to the previous sample (end of line): row<=row+1, col<=0, base<=base+H_PIXELS. A row is counted only if at least one byte was seen in it.
  - vsync=1: pulse frame_done (only if row>0), go to VBLANK.
- BYTE2:
  - href=1: latch G,B from CAM_px_data. If col<H_PIXELS and row<V_PIXELS, then on this same edge set DP_RAM_data_in<={R,byte}, DP_RAM_addr_in<=base+col, DP_RAM_regW<=1. Otherwise set err_overrun and do not write. col<=col+1 (saturate at H_PIXELS). Return to BYTE1.
  - href=0: discard R, set err_half_px, apply end-of-line handling, go to BYTE1.
  - vsync=1: discard R, set err_half_px, apply frame-end handling.

Timing and write rules:
- Latency: DP_RAM_* are valid in the cycle after the posedge that samples byte2. regW is high for exactly one cycle and is deasserted on the next edge unless another pixel completes.
- For a continuous line, writes occur every 2nd cycle. Address sequence for row r is r*H_PIXELS .. r*H_PIXELS+H_PIXELS-1.
- A short line leaves its unused addresses unwritten; the next row still starts at (r+1)*H_PIXELS.
- Addresses are never above H_PIXELS*V_PIXELS-1 (19199).

Simultaneous events and error flags:
- vsync=1 takes priority over href. A byte sampled with both high is ignored.
- err_* are sticky and cleared only by reset.
- frame_done is asserted one cycle after the vsync rising edge is sampled, and not in the same cycle as regW for a discarded pixel.

Test Plan:
- Reset hold 5 cycles, then 4 blanking rows (vsync high 2 rows, low 2), 120 rows of 320 bytes alternating 00/0F,00/0F,00/F0,00/F0 with 4-cycle href gaps → 19200 writes. addr 0..19199 monotonic. data at addr 0,1 = 0x00F; addr 2,3 = 0x0F0. frame_done one pulse. Both err flags 0.
- Row of 318 bytes (159 pixels) at row 5 → addr 959 unwritten. Row 6 first write at addr 960. err flags 0.
- Row of 324 bytes → 160 writes for that row, err_overrun=1. Next row still starts at row*160.
- href drops after an odd byte count (301 bytes) → 150 writes, err_half_px=1. Next row aligned.
- rst pulsed low mid-row 50 → outputs 0 immediately (asynchronous). No writes until the next vsync high→low. The new frame restarts at addr 0.
- vsync rises while href=1 mid-line → the write in progress completes only if byte2 was sampled before vsync. frame_done pulses once. No writes during VBLANK.

Source files
------------

// File: rtl/cam_capture_rgb444.sv
// Camera capture stage: pairs OV7670 RGB444 bytes into 12-bit pixels and writes them
// row-aligned into a H_PIXELS x V_PIXELS frame buffer, flagging framing errors.
module cam_capture_rgb444 #(
  parameter int H_PIXELS = 160,
  parameter int V_PIXELS = 120,
  parameter int AW       = 15,
  parameter int DW       = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          CAM_vsync,
  input  logic          CAM_href,
  input  logic [7:0]    CAM_px_data,
  output logic [AW-1:0] DP_RAM_addr_in,
  output logic [DW-1:0] DP_RAM_data_in,
  output logic          DP_RAM_regW,
  output logic          frame_done,
  output logic          err_half_px,
  output logic          err_overrun
);

  localparam int CW = $clog2(H_PIXELS + 1);
  localparam int RW = $clog2(V_PIXELS + 1);
  localparam logic [CW-1:0] LP_COL_MAX  = CW'(H_PIXELS);
  localparam logic [RW-1:0] LP_ROW_MAX  = RW'(V_PIXELS);
  localparam logic [AW-1:0] LP_ROW_STEP = AW'(H_PIXELS);
  localparam logic [CW-1:0] LP_COL_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [RW-1:0] LP_ROW_ONE  = {{(RW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VBLANK = 2'd1,
    ST_BYTE1  = 2'd2,
    ST_BYTE2  = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [AW-1:0] r_base;
  logic [3:0]    r_red;
  logic          r_line_seen;

  logic          w_col_ok;
  logic          w_row_ok;
  logic          w_row_any;
  logic [AW-1:0] w_px_addr;

  assign w_col_ok  = (r_col < LP_COL_MAX);
  assign w_row_ok  = (r_row < LP_ROW_MAX);
  assign w_row_any = (r_row != {RW{1'b0}});
  assign w_px_addr = r_base + {{(AW-CW){1'b0}}, r_col};

  // Capture FSM: byte pairing, row/column tracking and the registered write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_col          <= {CW{1'b0}};
      r_row          <= {RW{1'b0}};
      r_base         <= {AW{1'b0}};
      r_red          <= 4'h0;
      r_line_seen    <= 1'b0;
      DP_RAM_addr_in <= {AW{1'b0}};
      DP_RAM_data_in <= {DW{1'b0}};
      DP_RAM_regW    <= 1'b0;
      frame_done     <= 1'b0;
      err_half_px    <= 1'b0;
      err_overrun    <= 1'b0;
    end else begin
      DP_RAM_regW <= 1'b0;
      frame_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (CAM_vsync) begin
            r_state <= ST_VBLANK;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_VBLANK: begin
          if (!CAM_vsync) begin
            r_row       <= {RW{1'b0}};
            r_col       <= {CW{1'b0}};
            r_base      <= {AW{1'b0}};
            r_line_seen <= 1'b0;
            r_state     <= ST_BYTE1;
          end else begin
            r_state <= ST_VBLANK;
          end
        end

        ST_BYTE1: begin
          if (CAM_vsync) begin
            frame_done <= w_row_any;
            r_state    <= ST_VBLANK;
          end else if (CAM_href) begin
            r_red       <= CAM_px_data[3:0];
            r_line_seen <= 1'b1;
            r_state     <= ST_BYTE2;
          end else if (r_line_seen) begin
            // First idle sample after a line with data: advance to the next row.
            r_line_seen <= 1'b0;
            r_col       <= {CW{1'b0}};
            if (w_row_ok) begin
              r_row  <= r_row + LP_ROW_ONE;
              r_base <= r_base + LP_ROW_STEP;
            end else begin
              r_row <= r_row;
            end
            r_state <= ST_BYTE1;
          end else begin
            r_state <= ST_BYTE1;
          end
        end

        ST_BYTE2: begin
          if (CAM_vsync) begin
            r_red       <= 4'h0;
            err_half_px <= 1'b1;
            frame_done  <= w_row_any;
            r_state     <= ST_VBLANK;
          end else if (CAM_href) begin
            if (w_col_ok && w_row_ok) begin
              DP_RAM_data_in <= DW'({r_red, CAM_px_data});
              DP_RAM_addr_in <= w_px_addr;
              DP_RAM_regW    <= 1'b1;
            end else begin
              err_overrun <= 1'b1;
            end
            if (w_col_ok) begin
              r_col <= r_col + LP_COL_ONE;
            end else begin
              r_col <= r_col;
            end
            r_state <= ST_BYTE1;
          end else begin
            // Line ended on a lone byte1: drop it and still realign to the next row.
            r_red       <= 4'h0;
            err_half_px <= 1'b1;
            r_line_seen <= 1'b0;
            r_col       <= {CW{1'b0}};
            if (w_row_ok) begin
              r_row  <= r_row + LP_ROW_ONE;
              r_base <= r_base + LP_ROW_STEP;
            end else begin
              r_row <= r_row;
            end
            r_state <= ST_BYTE1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
